// File: rtl/ibex_avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_avalon_pkg
// Description : Shared types and helpers for the Ibex-to-Avalon host bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_avalon_pkg;

  // Avalon-MM response codes carried back to the core with each completion.
  typedef enum logic [1:0] {
    OKAY        = 2'b00,
    RESERVED    = 2'b01,
    SLVERR      = 2'b10,
    DECODEERROR = 2'b11
  } avalon_resp_e;

  // Transaction type remembered per outstanding Avalon transfer.
  typedef enum logic {
    TXN_READ  = 1'b0,
    TXN_WRITE = 1'b1
  } txn_type_e;

  // Pointer width that stays at least one bit wide for a single-entry FIFO.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_avalon_host_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ibex_avalon_host_bridge_if
// Description : Ibex data-side request/response signals and the Avalon-MM
//               host signals of the bridge, bundled in one interface.
//               master = bridge view, slave = core + fabric view.
// Revision    : 1.0 - initial release
// ============================================================================
interface ibex_avalon_host_bridge_if #(
  parameter int unsigned ADDR_W = 32
);
  // Ibex side
  logic              host_read_i;
  logic              host_write_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic [3:0]        host_be_i;
  logic [31:0]       host_wdata_i;
  logic              host_busy_o;
  logic              host_rvalid_o;
  logic [31:0]       host_rdata_o;
  logic [1:0]        host_resp_o;
  logic              host_wrespvalid_o;
  // Avalon side
  logic [ADDR_W-1:0] avm_address_o;
  logic              avm_read_o;
  logic              avm_write_o;
  logic [3:0]        avm_byteenable_o;
  logic [31:0]       avm_writedata_o;
  logic              avm_waitrequest_i;
  logic [31:0]       avm_readdata_i;
  logic              avm_readdatavalid_i;
  logic [1:0]        avm_response_i;
  logic              avm_writeresponsevalid_i;

  modport master (
    input  host_read_i, host_write_i, host_addr_i, host_be_i, host_wdata_i,
    output host_busy_o, host_rvalid_o, host_rdata_o, host_resp_o, host_wrespvalid_o,
    output avm_address_o, avm_read_o, avm_write_o, avm_byteenable_o, avm_writedata_o,
    input  avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i, avm_response_i,
    input  avm_writeresponsevalid_i
  );

  modport slave (
    output host_read_i, host_write_i, host_addr_i, host_be_i, host_wdata_i,
    input  host_busy_o, host_rvalid_o, host_rdata_o, host_resp_o, host_wrespvalid_o,
    input  avm_address_o, avm_read_o, avm_write_o, avm_byteenable_o, avm_writedata_o,
    output avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i, avm_response_i,
    output avm_writeresponsevalid_i
  );

endinterface
`default_nettype wire

// File: rtl/ibex_avalon_txn_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ibex_avalon_txn_fifo
// Description : Small in-order FIFO of transaction types used to match Avalon
//               responses to the transfers that produced them.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_avalon_txn_fifo
  import ibex_avalon_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      i_push,
  input  txn_type_e i_push_type,
  input  logic      i_pop,
  output logic      o_full,
  output logic      o_empty,
  output txn_type_e o_head
);

  localparam int unsigned      PTR_W      = ptr_width(DEPTH);
  localparam int unsigned      CNT_W      = PTR_W + 1;
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

  txn_type_e        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Overflow/underflow requests are ignored so the count can never wrap.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage and pointers; pointers wrap explicitly so any DEPTH works.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= TXN_READ;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_type;
        r_wr_ptr        <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ibex_avalon_host_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ibex_avalon_host_bridge
// Description : Ibex data bus to pipelined Avalon-MM host. Registers the
//               command, tracks outstanding transfers in order and returns
//               read data / write completions to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_avalon_host_bridge
  import ibex_avalon_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          USE_WRESP       = 1'b1,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  ibex_avalon_host_bridge_if.master        bus,
  output logic                             proto_err_o
);

  logic              r_cmd_valid;
  logic              r_cmd_we;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [3:0]        r_cmd_be;
  logic [31:0]       r_cmd_wdata;

  logic              r_rvalid;
  logic              r_wrespvalid;
  logic [31:0]       r_rdata;
  avalon_resp_e      r_resp;
  logic              r_proto_err;

  logic              w_trk_full;
  logic              w_trk_empty;
  txn_type_e         w_trk_head;
  logic              w_avm_read;
  logic              w_avm_write;
  logic              w_issue;
  logic              w_busy;
  logic              w_accept;
  logic              w_rd_beat;
  logic              w_wr_beat;
  logic              w_head_rd;
  logic              w_head_wr;
  logic              w_pop_rd;
  logic              w_pop_wr;
  logic              w_unexpected;

  // Issue path: busy depends only on registered state and waitrequest, so
  // there is no combinational loop back through the core's request.
  assign w_avm_read  = r_cmd_valid & ~r_cmd_we & ~w_trk_full;
  assign w_avm_write = r_cmd_valid &  r_cmd_we & ~w_trk_full;
  assign w_issue     = (w_avm_read | w_avm_write) & ~bus.avm_waitrequest_i;
  assign w_busy      = r_cmd_valid & ~w_issue;
  assign w_accept    = (bus.host_read_i | bus.host_write_i) & ~w_busy;

  // Completion matching against the oldest outstanding transfer.
  assign w_rd_beat    = bus.avm_readdatavalid_i;
  assign w_wr_beat    = USE_WRESP ? bus.avm_writeresponsevalid_i : 1'b0;
  assign w_head_rd    = ~w_trk_empty & (w_trk_head == TXN_READ);
  assign w_head_wr    = ~w_trk_empty & (w_trk_head == TXN_WRITE);
  assign w_pop_rd     = w_rd_beat & w_head_rd;
  // Without a write-response channel a write at the head retires on its own,
  // but only once every earlier read has returned (it is then the head).
  assign w_pop_wr     = w_head_wr & (USE_WRESP ? bus.avm_writeresponsevalid_i : ~w_rd_beat);
  assign w_unexpected = (w_rd_beat & ~w_head_rd) | (w_wr_beat & ~w_head_wr);

  assign bus.avm_read_o        = w_avm_read;
  assign bus.avm_write_o       = w_avm_write;
  assign bus.avm_address_o     = r_cmd_addr;
  assign bus.avm_byteenable_o  = r_cmd_be;
  assign bus.avm_writedata_o   = r_cmd_wdata;
  assign bus.host_busy_o       = w_busy;
  assign bus.host_rvalid_o     = r_rvalid;
  assign bus.host_wrespvalid_o = r_wrespvalid;
  assign bus.host_rdata_o      = r_rdata;
  assign bus.host_resp_o       = r_resp;
  assign proto_err_o           = r_proto_err;

  ibex_avalon_txn_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_issue),
    .i_push_type (r_cmd_we ? TXN_WRITE : TXN_READ),
    .i_pop       (w_pop_rd | w_pop_wr),
    .o_full      (w_trk_full),
    .o_empty     (w_trk_empty),
    .o_head      (w_trk_head)
  );

  // Command register: loads on accept (write wins a read/write tie), clears on issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cmd_valid <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_be    <= '0;
      r_cmd_wdata <= '0;
    end else if (w_accept) begin
      r_cmd_valid <= 1'b1;
      r_cmd_we    <= bus.host_write_i;
      r_cmd_addr  <= bus.host_addr_i;
      r_cmd_be    <= bus.host_be_i;
      r_cmd_wdata <= bus.host_wdata_i;
    end else if (w_issue) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Host-side completion beats, one cycle after the matching Avalon beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid     <= 1'b0;
      r_wrespvalid <= 1'b0;
      r_rdata      <= '0;
      r_resp       <= OKAY;
    end else begin
      r_rvalid     <= w_pop_rd;
      r_wrespvalid <= w_pop_wr;
      if (w_pop_rd) begin
        r_rdata <= bus.avm_readdata_i;
        r_resp  <= avalon_resp_e'(bus.avm_response_i);
      end else if (w_pop_wr) begin
        if (USE_WRESP) begin
          r_resp <= avalon_resp_e'(bus.avm_response_i);
        end else begin
          r_resp <= OKAY;
        end
      end
    end
  end

  // Sticky flag for responses that match no outstanding transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_proto_err <= 1'b0;
    end else if (w_unexpected) begin
      r_proto_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibex_avalon_host_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_avalon_host_bridge
// Description : Directed self-checking bench for ibex_avalon_host_bridge,
//               one instance with write responses, one synthesizing them.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ibex_avalon_host_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic perr1;
  logic perr0;

  always #5 clk = ~clk;

  ibex_avalon_host_bridge_if #(.ADDR_W(32)) b1 ();
  ibex_avalon_host_bridge_if #(.ADDR_W(32)) b0 ();

  ibex_avalon_host_bridge #(.MAX_OUTSTANDING(4), .USE_WRESP(1'b1), .ADDR_W(32)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b1), .proto_err_o(perr1));

  ibex_avalon_host_bridge #(.MAX_OUTSTANDING(4), .USE_WRESP(1'b0), .ADDR_W(32)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b0), .proto_err_o(perr0));

  // Simultaneous read and write requests are legal but flagged for attention.
  always @(posedge clk) begin
    assert (!(b1.host_read_i && b1.host_write_i)) else $warning("read and write both high on b1");
    assert (!(b0.host_read_i && b0.host_write_i)) else $warning("read and write both high on b0");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_all();
    b1.host_read_i = 0; b1.host_write_i = 0; b1.host_addr_i = 0; b1.host_be_i = 0;
    b1.host_wdata_i = 0; b1.avm_waitrequest_i = 0; b1.avm_readdata_i = 0;
    b1.avm_readdatavalid_i = 0; b1.avm_response_i = 0; b1.avm_writeresponsevalid_i = 0;
    b0.host_read_i = 0; b0.host_write_i = 0; b0.host_addr_i = 0; b0.host_be_i = 0;
    b0.host_wdata_i = 0; b0.avm_waitrequest_i = 0; b0.avm_readdata_i = 0;
    b0.avm_readdatavalid_i = 0; b0.avm_response_i = 0; b0.avm_writeresponsevalid_i = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    mid();
    total++; if ({b1.host_busy_o, b1.avm_read_o, b1.avm_write_o, b1.host_rvalid_o, b1.host_wrespvalid_o, perr1} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl1: got %b want 000000", {b1.host_busy_o, b1.avm_read_o, b1.avm_write_o, b1.host_rvalid_o, b1.host_wrespvalid_o, perr1}); end
    total++; if ({b0.host_busy_o, b0.avm_read_o, b0.avm_write_o, b0.host_rvalid_o, b0.host_wrespvalid_o, perr0} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl0: got %b want 000000", {b0.host_busy_o, b0.avm_read_o, b0.avm_write_o, b0.host_rvalid_o, b0.host_wrespvalid_o, perr0}); end
    total++; if ({b1.avm_address_o, b1.avm_byteenable_o, b1.avm_writedata_o, b1.host_rdata_o, b1.host_resp_o} !== 102'd0) begin
      bad++; $display("FAIL reset_data1: got %h want 0", {b1.avm_address_o, b1.avm_byteenable_o, b1.avm_writedata_o, b1.host_rdata_o, b1.host_resp_o}); end
    apply_reset();
  endtask

  task automatic test_single_read();
    logic busy_seen = 1'b0;
    step(); b1.host_read_i = 1; b1.host_addr_i = 32'h40; b1.host_be_i = 4'hF;
    mid(); busy_seen |= b1.host_busy_o;
    step(); b1.host_read_i = 0; b1.host_addr_i = 0;
    mid(); busy_seen |= b1.host_busy_o;
    total++; if (b1.avm_read_o !== 1'b1) begin bad++; $display("FAIL rd_issue: got %b want 1", b1.avm_read_o); end
    total++; if (b1.avm_address_o !== 32'h40) begin bad++; $display("FAIL rd_addr: got %h want 00000040", b1.avm_address_o); end
    step(); mid(); busy_seen |= b1.host_busy_o;
    total++; if (b1.avm_read_o !== 1'b0) begin bad++; $display("FAIL rd_once: got %b want 0", b1.avm_read_o); end
    step(); mid();
    step(); b1.avm_readdatavalid_i = 1; b1.avm_readdata_i = 32'hDEADBEEF; b1.avm_response_i = 2'b00;
    mid();
    total++; if (b1.host_rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_early: got %b want 0", b1.host_rvalid_o); end
    step(); b1.avm_readdatavalid_i = 0; b1.avm_readdata_i = 0;
    mid();
    total++; if (b1.host_rvalid_o !== 1'b1) begin bad++; $display("FAIL rd_rvalid: got %b want 1", b1.host_rvalid_o); end
    total++; if (b1.host_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata: got %h want deadbeef", b1.host_rdata_o); end
    total++; if (b1.host_resp_o !== 2'b00) begin bad++; $display("FAIL rd_resp: got %b want 00", b1.host_resp_o); end
    step(); mid();
    total++; if (b1.host_rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_pulse: got %b want 0", b1.host_rvalid_o); end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL rd_busy: got %b want 0", busy_seen); end
  endtask

  task automatic test_write_wait();
    int accepts = 0;
    step(); b1.avm_waitrequest_i = 1; b1.host_write_i = 1; b1.host_addr_i = 32'h100;
    b1.host_be_i = 4'b0011; b1.host_wdata_i = 32'hCAFEF00D;
    mid();
    step(); b1.host_write_i = 0; b1.host_addr_i = 0; b1.host_be_i = 0; b1.host_wdata_i = 0;
    for (int k = 0; k < 4; k++) begin
      mid();
      if (b1.avm_write_o && !b1.avm_waitrequest_i) accepts++;
      total++; if ({b1.avm_write_o, b1.host_busy_o} !== 2'b11) begin bad++; $display("FAIL wr_hold%0d: write,busy got %b want 11", k, {b1.avm_write_o, b1.host_busy_o}); end
      total++; if ({b1.avm_address_o, b1.avm_byteenable_o, b1.avm_writedata_o} !== {32'h100, 4'b0011, 32'hCAFEF00D}) begin
        bad++; $display("FAIL wr_stable%0d: got %h want 00000100_3_cafef00d", k, {b1.avm_address_o, b1.avm_byteenable_o, b1.avm_writedata_o}); end
      if (k < 3) step();
    end
    step(); b1.avm_waitrequest_i = 0;
    mid();
    if (b1.avm_write_o && !b1.avm_waitrequest_i) accepts++;
    total++; if (b1.host_busy_o !== 1'b0) begin bad++; $display("FAIL wr_release: busy got %b want 0", b1.host_busy_o); end
    step(); mid();
    if (b1.avm_write_o && !b1.avm_waitrequest_i) accepts++;
    total++; if (accepts !== 1) begin bad++; $display("FAIL wr_accepts: got %0d want 1", accepts); end
    // Write response with DECODEERROR passes through on the write-response instance.
    step(); b1.avm_writeresponsevalid_i = 1; b1.avm_response_i = 2'b11;
    mid();
    total++; if (b1.host_wrespvalid_o !== 1'b0) begin bad++; $display("FAIL wresp_early: got %b want 0", b1.host_wrespvalid_o); end
    step(); b1.avm_writeresponsevalid_i = 0; b1.avm_response_i = 0;
    mid();
    total++; if ({b1.host_wrespvalid_o, b1.host_rvalid_o, b1.host_resp_o} !== 4'b1011) begin
      bad++; $display("FAIL wresp_pass: wresp,rvalid,resp got %b want 1011", {b1.host_wrespvalid_o, b1.host_rvalid_o, b1.host_resp_o}); end
    total++; if (perr1 !== 1'b0) begin bad++; $display("FAIL wr_perr: got %b want 0", perr1); end
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    int nrv = 0;
    step(); b1.host_read_i = 1; b1.host_addr_i = 32'h200;
    for (int c = 0; c < 5; c++) begin
      mid();
      if (b1.avm_read_o && !b1.avm_waitrequest_i) issued++;
      nrv += int'(b1.host_rvalid_o);
      total++; if (b1.host_busy_o !== 1'b0) begin bad++; $display("FAIL b2b_busy%0d: got %b want 0", c, b1.host_busy_o); end
      step(); b1.host_addr_i = b1.host_addr_i + 32'd4;
    end
    total++; if (issued !== 4) begin bad++; $display("FAIL b2b_issued: got %0d want 4", issued); end
    for (int c = 5; c < 8; c++) begin
      mid();
      total++; if ({b1.avm_read_o, b1.host_busy_o} !== 2'b01) begin bad++; $display("FAIL b2b_full%0d: read,busy got %b want 01", c, {b1.avm_read_o, b1.host_busy_o}); end
      step();
    end
    b1.avm_readdatavalid_i = 1; b1.avm_readdata_i = 32'h1;
    mid();
    total++; if (b1.avm_read_o !== 1'b0) begin bad++; $display("FAIL b2b_hold: got %b want 0", b1.avm_read_o); end
    step(); b1.avm_readdatavalid_i = 0;
    mid();
    nrv += int'(b1.host_rvalid_o);
    total++; if ({b1.avm_read_o, b1.host_busy_o} !== 2'b10) begin bad++; $display("FAIL b2b_fifth: read,busy got %b want 10", {b1.avm_read_o, b1.host_busy_o}); end
    total++; if (b1.avm_address_o !== 32'h210) begin bad++; $display("FAIL b2b_addr5: got %h want 00000210", b1.avm_address_o); end
    step(); b1.host_read_i = 0; b1.avm_readdatavalid_i = 1;
    mid();
    nrv += int'(b1.host_rvalid_o);
    total++; if ({b1.avm_read_o, b1.host_busy_o} !== 2'b01) begin bad++; $display("FAIL b2b_sixth_hold: read,busy got %b want 01", {b1.avm_read_o, b1.host_busy_o}); end
    step();
    mid();
    nrv += int'(b1.host_rvalid_o);
    total++; if (b1.avm_address_o !== 32'h214 || b1.avm_read_o !== 1'b1) begin
      bad++; $display("FAIL b2b_sixth: addr %h read %b want 00000214 1", b1.avm_address_o, b1.avm_read_o); end
    for (int c = 12; c < 15; c++) begin
      step(); mid();
      nrv += int'(b1.host_rvalid_o);
    end
    step(); b1.avm_readdatavalid_i = 0;
    mid();
    nrv += int'(b1.host_rvalid_o);
    total++; if (nrv !== 6) begin bad++; $display("FAIL b2b_rvalids: got %0d want 6", nrv); end
    total++; if (perr1 !== 1'b0) begin bad++; $display("FAIL b2b_perr: got %b want 0", perr1); end
  endtask

  task automatic test_synth_wresp();
    logic exp_rv;
    logic exp_wr;
    step(); b0.host_read_i = 1; b0.host_addr_i = 32'h300;
    mid();
    step(); b0.host_read_i = 0; b0.host_write_i = 1; b0.host_addr_i = 32'h304; b0.host_wdata_i = 32'h1;
    mid();
    step(); b0.host_write_i = 0; b0.host_read_i = 1; b0.host_addr_i = 32'h308;
    mid();
    step(); b0.host_read_i = 0;
    for (int c = 3; c < 13; c++) begin
      b0.avm_readdatavalid_i      = (c == 6 || c == 10);
      b0.avm_readdata_i           = 32'h1000 + c;
      b0.avm_response_i           = (c == 7) ? 2'b10 : 2'b00;
      b0.avm_writeresponsevalid_i = (c == 4);
      exp_rv = (c == 7 || c == 11);
      exp_wr = (c == 8);
      mid();
      total++; if ({b0.host_rvalid_o, b0.host_wrespvalid_o} !== {exp_rv, exp_wr}) begin
        bad++; $display("FAIL synth_order_c%0d: rvalid,wresp got %b want %b", c, {b0.host_rvalid_o, b0.host_wrespvalid_o}, {exp_rv, exp_wr}); end
      if (c == 8) begin
        total++; if (b0.host_resp_o !== 2'b00) begin bad++; $display("FAIL synth_resp: got %b want 00", b0.host_resp_o); end
      end
      if (c == 11) begin
        total++; if (b0.host_rdata_o !== 32'h100A) begin bad++; $display("FAIL synth_rdata2: got %h want 0000100a", b0.host_rdata_o); end
      end
      step();
    end
    b0.avm_readdatavalid_i = 0; b0.avm_response_i = 0; b0.avm_writeresponsevalid_i = 0;
    mid();
    total++; if (perr0 !== 1'b0) begin bad++; $display("FAIL synth_perr: got %b want 0", perr0); end
  endtask

  task automatic test_proto_err();
    step(); b1.avm_readdatavalid_i = 1; b1.avm_readdata_i = 32'h1234;
    mid();
    step(); b1.avm_readdatavalid_i = 0;
    mid();
    total++; if (b1.host_rvalid_o !== 1'b0) begin bad++; $display("FAIL perr_drop: rvalid got %b want 0", b1.host_rvalid_o); end
    total++; if (perr1 !== 1'b1) begin bad++; $display("FAIL perr_set: got %b want 1", perr1); end
    repeat (3) step();
    mid();
    total++; if (perr1 !== 1'b1) begin bad++; $display("FAIL perr_sticky: got %b want 1", perr1); end
  endtask

  task automatic test_reset_mid();
    step(); b1.host_read_i = 1; b1.host_addr_i = 32'h500;
    mid();
    step(); b1.host_read_i = 1; b1.host_addr_i = 32'h504;
    mid();
    step(); b1.host_read_i = 0; b1.avm_waitrequest_i = 1;
    b1.avm_readdatavalid_i = 1; b1.avm_readdata_i = 32'hA5A5A5A5;
    mid();
    step(); b1.avm_readdatavalid_i = 0;
    mid();
    total++; if ({b1.host_rvalid_o, b1.avm_read_o, b1.host_busy_o} !== 3'b111) begin
      bad++; $display("FAIL rst_pre: rvalid,read,busy got %b want 111", {b1.host_rvalid_o, b1.avm_read_o, b1.host_busy_o}); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({b1.host_rvalid_o, b1.avm_read_o, b1.host_busy_o, b1.host_wrespvalid_o} !== 4'b0000) begin
      bad++; $display("FAIL rst_async: rvalid,read,busy,wresp got %b want 0000", {b1.host_rvalid_o, b1.avm_read_o, b1.host_busy_o, b1.host_wrespvalid_o}); end
    total++; if ({b1.avm_address_o, b1.host_rdata_o} !== 64'd0) begin
      bad++; $display("FAIL rst_async_data: got %h want 0", {b1.avm_address_o, b1.host_rdata_o}); end
    idle_all();
    step(); rst_n = 1'b1;
    step(); b1.avm_readdatavalid_i = 1; b1.avm_readdata_i = 32'h77;
    mid();
    step(); b1.avm_readdatavalid_i = 0;
    mid();
    total++; if ({b1.host_rvalid_o, perr1} !== 2'b01) begin
      bad++; $display("FAIL rst_late: rvalid,perr got %b want 01", {b1.host_rvalid_o, perr1}); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_read();
    test_write_wait();
    apply_reset();
    test_back_to_back();
    test_synth_wresp();
    apply_reset();
    test_proto_err();
    apply_reset();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
